id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the register file. Captures the register file's read data, immediate and decode control each cycle and presents them to EX.
- Contains load-use hazard detection. It inserts a one-cycle bubble and stalls PC and IF/ID when the instruction in EX is a load whose destination is read by the instruction in decode.
- Also handles branch flush and holds its contents on a downstream stall.

Parameters:
- DATA_W, 32, width of register data and immediate
- ADDR_W, 5, register address width
- ALUOP_W, 3, width of ALU operation code

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  decode slot holds a real instruction
- RSaddr_i  in  ADDR_W  rs address being read
- RTaddr_i  in  ADDR_W  rt address being read
- uses_rs_i  in  1  instruction actually consumes rs
- uses_rt_i  in  1  instruction actually consumes rt
- RDaddr_i  in  ADDR_W  destination register
- RSdata_i  in  DATA_W  rs value from register file
- RTdata_i  in  DATA_W  rt value from register file
- imm_i  in  DATA_W  sign/zero-extended immediate
- RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i  in  1 each  decode control
- ALUOp_i  in  ALUOP_W  ALU operation
- flush_i  in  1  kill decode instruction (taken branch/jump)
- stall_i  in  1  downstream (MEM) stall; hold everything
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- valid_o, RSaddr_o, RTaddr_o, RDaddr_o, RSdata_o, RTdata_o, imm_o  out  registered copies
- RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, ALUOp_o  out  registered control

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset: all outputs register to 0 on the rst_i edge. stall_o = 0 while rst_i = 1.
- hazard is combinational and is 1 when all of these hold:
  - valid_i & valid_o & MemRead_o & (RDaddr_o != 0)
  - (uses_rs_i & RSaddr_i == RDaddr_o) | (uses_rt_i & RTaddr_i == RDaddr_o)
- stall_o = ~rst_i & ~flush_i & (hazard | stall_i).
- Register update priority, evaluated each rising edge:
  1. rst_i: clear all.
  2. flush_i: bubble. Clear valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o. Load data and address fields from the inputs. flush_i wins over stall_i.
  3. stall_i: hold every output unchanged.
  4. hazard: bubble, same as flush. Decode is held by stall_o and re-presents the instruction next cycle.
  5. Otherwise: load all fields from the inputs.
- Latency: 1 cycle from input to output.
- A load-use dependency costs exactly one bubble. After the bubble, valid_o = 0, so the hazard clears and the instruction advances.
- An r0 destination never triggers a stall.
- A bubble or invalid instruction always has RegWrite_o = MemWrite_o = MemRead_o = 0.
- valid_i = 0 loads valid_o = 0 and clears the control bits, as for a bubble.
- Forwarding is outside this block; only load-use needs a stall.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt_o [31:0].
  - Increments on each edge where a hazard bubble is inserted, i.e. hazard & ~stall_i & ~flush_i & ~rst_i.
  - Saturates at 32'hFFFF_FFFF. Reset clears it to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - ALUOp encodings
  - REG_ZERO = 0
  - DATA_W/ADDR_W defaults
  - bubble control constant (all-zero control bundle)
- Sub-module load_use_hazard (combinational): computes hazard from decode addresses and EX-stage RDaddr/MemRead/valid. Reused by the hazard unit for stall_o.

Test Plan:
- lw $9 in EX (MemRead_o=1, RDaddr_o=9); decode add reads rs=9 with uses_rs_i=1 -> stall_o=1; next cycle valid_o=0, RegWrite_o=0; the following cycle the add appears with RSaddr_o=9.
- lw $0 in EX; decode reads rs=0 -> stall_o=0, no bubble.
- lw $9 in EX; decode reads rt=9 with uses_rt_i=0 (I-type dest) -> no stall.
- Plain add in EX (MemRead_o=0) writing $9; decode reads $9 -> no stall; data passes through in 1 cycle.
- stall_i=1 for 3 cycles with RSdata_i changing -> all outputs hold their pre-stall values and stall_o=1; release -> new data loads.
- flush_i=1 together with hazard and stall_i -> stall_o=0; next cycle valid_o=0 and control bits 0.
- rst_i=1 mid-stream -> all outputs 0 next edge.
- With ID_EX_STALL_CNT_EN defined: two load-use bubbles -> stall_cnt_o=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared pipeline types and constants (ALU op codes, widths,
//            bubble control bundle) used by the ID/EX stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int ADDR_W_DEF  = 5;
   localparam int ALUOP_W_DEF = 3;

   // Register r0 is hard-wired to zero, so writes to it never create hazards
   localparam int REG_ZERO = 0;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5,
      ALU_SLL = 3'd6,
      ALU_SRL = 3'd7
   } alu_op_e;

   // Side-effecting controls that must be zero in a bubble
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } side_ctrl_t;

   localparam side_ctrl_t CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module   : id_ex_stage_if
// Purpose  : Decode-side inputs and EX-side outputs of the ID/EX stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int ALUOP_W = 3
) ();

   logic               valid_i;
   logic [ADDR_W-1:0]  RSaddr_i;
   logic [ADDR_W-1:0]  RTaddr_i;
   logic               uses_rs_i;
   logic               uses_rt_i;
   logic [ADDR_W-1:0]  RDaddr_i;
   logic [DATA_W-1:0]  RSdata_i;
   logic [DATA_W-1:0]  RTdata_i;
   logic [DATA_W-1:0]  imm_i;
   logic               RegWrite_i;
   logic               MemRead_i;
   logic               MemWrite_i;
   logic               MemtoReg_i;
   logic               ALUSrc_i;
   logic [ALUOP_W-1:0] ALUOp_i;
   logic               flush_i;
   logic               stall_i;

   logic               stall_o;
   logic               valid_o;
   logic [ADDR_W-1:0]  RSaddr_o;
   logic [ADDR_W-1:0]  RTaddr_o;
   logic [ADDR_W-1:0]  RDaddr_o;
   logic [DATA_W-1:0]  RSdata_o;
   logic [DATA_W-1:0]  RTdata_o;
   logic [DATA_W-1:0]  imm_o;
   logic               RegWrite_o;
   logic               MemRead_o;
   logic               MemWrite_o;
   logic               MemtoReg_o;
   logic               ALUSrc_o;
   logic [ALUOP_W-1:0] ALUOp_o;

   modport slave (
      input  valid_i, RSaddr_i, RTaddr_i, uses_rs_i, uses_rt_i, RDaddr_i,
             RSdata_i, RTdata_i, imm_i, RegWrite_i, MemRead_i, MemWrite_i,
             MemtoReg_i, ALUSrc_i, ALUOp_i, flush_i, stall_i,
      output stall_o, valid_o, RSaddr_o, RTaddr_o, RDaddr_o, RSdata_o,
             RTdata_o, imm_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
             ALUSrc_o, ALUOp_o
   );

   modport master (
      output valid_i, RSaddr_i, RTaddr_i, uses_rs_i, uses_rt_i, RDaddr_i,
             RSdata_i, RTdata_i, imm_i, RegWrite_i, MemRead_i, MemWrite_i,
             MemtoReg_i, ALUSrc_i, ALUOp_i, flush_i, stall_i,
      input  stall_o, valid_o, RSaddr_o, RTaddr_o, RDaddr_o, RSdata_o,
             RTdata_o, imm_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
             ALUSrc_o, ALUOp_o
   );

endinterface

`default_nettype wire

// File: rtl/load_use_hazard.sv
// ============================================================================
// Module   : load_use_hazard
// Purpose  : Combinational load-use detector: decode reads the register a
//            load currently in EX is about to write.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module load_use_hazard
   import pipe_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              valid_id_i,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   input  logic              uses_rs_i,
   input  logic              uses_rt_i,
   input  logic              valid_ex_i,
   input  logic              mem_read_ex_i,
   input  logic [ADDR_W-1:0] rd_addr_ex_i,
   output logic              hazard_o
);

   logic load_in_ex;
   logic rs_match;
   logic rt_match;

   always_comb begin
      load_in_ex = valid_id_i & valid_ex_i & mem_read_ex_i &
                   (rd_addr_ex_i != ADDR_W'(REG_ZERO));
      rs_match   = uses_rs_i & (rs_addr_i == rd_addr_ex_i);
      rt_match   = uses_rt_i & (rt_addr_i == rd_addr_ex_i);
      hazard_o   = load_in_ex & (rs_match | rt_match);
   end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use bubble insertion, branch
//            flush and downstream stall hold. Optional bubble counter enabled
//            by defining ID_EX_STALL_CNT_EN (adds stall_cnt_o).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int ALUOP_W = ALUOP_W_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   id_ex_stage_if.slave bus
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt_o
`endif
);

   typedef struct packed {
      logic               valid;
      logic [ADDR_W-1:0]  rs_addr;
      logic [ADDR_W-1:0]  rt_addr;
      logic [ADDR_W-1:0]  rd_addr;
      logic [DATA_W-1:0]  rs_data;
      logic [DATA_W-1:0]  rt_data;
      logic [DATA_W-1:0]  imm;
      side_ctrl_t         ctrl;
      logic               alu_src;
      logic [ALUOP_W-1:0] alu_op;
   } stage_t;

   stage_t stage_q;
   stage_t stage_d;
   stage_t incoming;
   logic   hazard;

   load_use_hazard #(
      .ADDR_W (ADDR_W)
   ) u_hazard (
      .valid_id_i    (bus.valid_i),
      .rs_addr_i     (bus.RSaddr_i),
      .rt_addr_i     (bus.RTaddr_i),
      .uses_rs_i     (bus.uses_rs_i),
      .uses_rt_i     (bus.uses_rt_i),
      .valid_ex_i    (stage_q.valid),
      .mem_read_ex_i (stage_q.ctrl.mem_read),
      .rd_addr_ex_i  (stage_q.rd_addr),
      .hazard_o      (hazard)
   );

   always_comb begin
      incoming.valid           = bus.valid_i;
      incoming.rs_addr         = bus.RSaddr_i;
      incoming.rt_addr         = bus.RTaddr_i;
      incoming.rd_addr         = bus.RDaddr_i;
      incoming.rs_data         = bus.RSdata_i;
      incoming.rt_data         = bus.RTdata_i;
      incoming.imm             = bus.imm_i;
      incoming.ctrl.reg_write  = bus.RegWrite_i;
      incoming.ctrl.mem_read   = bus.MemRead_i;
      incoming.ctrl.mem_write  = bus.MemWrite_i;
      incoming.ctrl.mem_to_reg = bus.MemtoReg_i;
      incoming.alu_src         = bus.ALUSrc_i;
      incoming.alu_op          = bus.ALUOp_i;

      // A bubble still carries the decode data/address fields; only the
      // valid bit and side-effecting controls are killed.
      stage_d = stage_q;
      if (bus.flush_i) begin
         stage_d       = incoming;
         stage_d.valid = 1'b0;
         stage_d.ctrl  = CTRL_BUBBLE;
      end else if (bus.stall_i) begin
         stage_d = stage_q;
      end else if (hazard) begin
         stage_d       = incoming;
         stage_d.valid = 1'b0;
         stage_d.ctrl  = CTRL_BUBBLE;
      end else begin
         stage_d = incoming;
         if (!bus.valid_i) begin
            stage_d.ctrl = CTRL_BUBBLE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign bus.stall_o    = ~rst_i & ~bus.flush_i & (hazard | bus.stall_i);
   assign bus.valid_o    = stage_q.valid;
   assign bus.RSaddr_o   = stage_q.rs_addr;
   assign bus.RTaddr_o   = stage_q.rt_addr;
   assign bus.RDaddr_o   = stage_q.rd_addr;
   assign bus.RSdata_o   = stage_q.rs_data;
   assign bus.RTdata_o   = stage_q.rt_data;
   assign bus.imm_o      = stage_q.imm;
   assign bus.RegWrite_o = stage_q.ctrl.reg_write;
   assign bus.MemRead_o  = stage_q.ctrl.mem_read;
   assign bus.MemWrite_o = stage_q.ctrl.mem_write;
   assign bus.MemtoReg_o = stage_q.ctrl.mem_to_reg;
   assign bus.ALUSrc_o   = stage_q.alu_src;
   assign bus.ALUOp_o    = stage_q.alu_op;

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   // Counts only edges where a load-use bubble is actually inserted
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hazard && !bus.stall_i && !bus.flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed + randomized bench for id_ex_stage against a
//            transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
   import pipe_pkg::*;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam int ALUOP_W = 3;

   typedef struct {
      logic               rst;
      logic               flush;
      logic               stall;
      logic               valid;
      logic [ADDR_W-1:0]  rs;
      logic [ADDR_W-1:0]  rt;
      logic               urs;
      logic               urt;
      logic [ADDR_W-1:0]  rd;
      logic [DATA_W-1:0]  rsd;
      logic [DATA_W-1:0]  rtd;
      logic [DATA_W-1:0]  imm;
      logic               rw;
      logic               mr;
      logic               mw;
      logic               m2r;
      logic               asrc;
      logic [ALUOP_W-1:0] aop;
   } stim_t;

   logic  clk;
   int    n_checks;
   int    n_errors;
   stim_t m;          // model of what EX currently holds
   logic [31:0] m_cnt;

   id_ex_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALUOP_W(ALUOP_W)) bus ();

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   logic rst;

   id_ex_stage #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ALUOP_W (ALUOP_W)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus)
`ifdef ID_EX_STALL_CNT_EN
      ,
      .stall_cnt_o (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the end (got timeout, want finish)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      s.valid = 1'b1;
      s.aop   = ALU_ADD;
      return s;
   endfunction

   // Load-use: EX holds a real load to a nonzero reg that decode really reads
   function automatic logic model_hazard(input stim_t s);
      logic reads_it;
      reads_it = (s.urs && s.rs == m.rd) || (s.urt && s.rt == m.rd);
      return s.valid && m.valid && m.mr && (m.rd != 0) && reads_it;
   endfunction

   task automatic apply(input stim_t s);
      rst            = s.rst;
      bus.flush_i    = s.flush;
      bus.stall_i    = s.stall;
      bus.valid_i    = s.valid;
      bus.RSaddr_i   = s.rs;
      bus.RTaddr_i   = s.rt;
      bus.uses_rs_i  = s.urs;
      bus.uses_rt_i  = s.urt;
      bus.RDaddr_i   = s.rd;
      bus.RSdata_i   = s.rsd;
      bus.RTdata_i   = s.rtd;
      bus.imm_i      = s.imm;
      bus.RegWrite_i = s.rw;
      bus.MemRead_i  = s.mr;
      bus.MemWrite_i = s.mw;
      bus.MemtoReg_i = s.m2r;
      bus.ALUSrc_i   = s.asrc;
      bus.ALUOp_i    = s.aop;
   endtask

   task automatic check_outputs();
      chk("valid_o",    bus.valid_o,    m.valid);
      chk("RSaddr_o",   bus.RSaddr_o,   m.rs);
      chk("RTaddr_o",   bus.RTaddr_o,   m.rt);
      chk("RDaddr_o",   bus.RDaddr_o,   m.rd);
      chk("RSdata_o",   bus.RSdata_o,   m.rsd);
      chk("RTdata_o",   bus.RTdata_o,   m.rtd);
      chk("imm_o",      bus.imm_o,      m.imm);
      chk("RegWrite_o", bus.RegWrite_o, m.rw);
      chk("MemRead_o",  bus.MemRead_o,  m.mr);
      chk("MemWrite_o", bus.MemWrite_o, m.mw);
      chk("MemtoReg_o", bus.MemtoReg_o, m.m2r);
      chk("ALUSrc_o",   bus.ALUSrc_o,   m.asrc);
      chk("ALUOp_o",    bus.ALUOp_o,    m.aop);
`ifdef ID_EX_STALL_CNT_EN
      chk("stall_cnt_o", stall_cnt, m_cnt);
`endif
   endtask

   // One clock: drive at negedge, check stall_o, advance model at posedge
   task automatic step(input stim_t s);
      logic hz;
      stim_t nxt;
      @(negedge clk);
      apply(s);
      #1;
      hz = model_hazard(s);
      chk("stall_o", bus.stall_o, !s.rst && !s.flush && (hz || s.stall));
      @(posedge clk);
      nxt = s;
      nxt.rst = 1'b0; nxt.flush = 1'b0; nxt.stall = 1'b0;
      if (s.rst) begin
         m     = '{default: '0};
         m_cnt = '0;
      end else if (s.flush || (!s.stall && hz)) begin
         m = nxt;
         m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.m2r = 1'b0;
         if (!s.flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else if (!s.stall) begin
         m = nxt;
         if (!s.valid) begin
            m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.m2r = 1'b0;
         end
      end
      #1;
      check_outputs();
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst   = ($urandom_range(0, 59) == 0);
      s.flush = ($urandom_range(0, 11) == 0);
      s.stall = ($urandom_range(0, 4) == 0);
      s.valid = ($urandom_range(0, 7) != 0);
      s.rs    = ADDR_W'($urandom_range(0, 3));
      s.rt    = ADDR_W'($urandom_range(0, 3));
      s.urs   = 1'($urandom_range(0, 1));
      s.urt   = 1'($urandom_range(0, 1));
      s.rd    = ADDR_W'($urandom_range(0, 3));
      s.rsd   = $urandom;
      s.rtd   = $urandom;
      s.imm   = $urandom;
      s.rw    = 1'($urandom_range(0, 1));
      s.mr    = ($urandom_range(0, 2) == 0);
      s.mw    = 1'($urandom_range(0, 1));
      s.m2r   = 1'($urandom_range(0, 1));
      s.asrc  = 1'($urandom_range(0, 1));
      s.aop   = ALUOP_W'($urandom_range(0, 7));
      return s;
   endfunction

   initial begin
      stim_t s;
      stim_t lw9;
      stim_t add;
      n_checks = 0;
      n_errors = 0;
      m        = '{default: '0};
      m_cnt    = '0;
      rst      = 1'b1;

      s = idle();
      s.rst = 1'b1;
      step(s);
      step(s);

      // lw $9 followed by a dependent add on rs
      lw9 = idle();
      lw9.rd = 9; lw9.mr = 1'b1; lw9.rw = 1'b1; lw9.m2r = 1'b1; lw9.asrc = 1'b1;
      lw9.rs = 2; lw9.urs = 1'b1; lw9.imm = 32'h10;
      step(lw9);
      add = idle();
      add.rs = 9; add.rt = 3; add.urs = 1'b1; add.urt = 1'b1; add.rd = 10; add.rw = 1'b1;
      add.rsd = 32'hAAAA_0001; add.rtd = 32'h5555_0002;
      step(add);
      chk("lu_bubble_valid", bus.valid_o, 1'b0);
      chk("lu_bubble_regwrite", bus.RegWrite_o, 1'b0);
      step(add);
      chk("lu_advance_valid", bus.valid_o, 1'b1);
      chk("lu_advance_rsaddr", bus.RSaddr_o, 64'd9);

      // lw $0 then read r0: no stall
      s = lw9; s.rd = 0;
      step(s);
      s = add; s.rs = 0;
      step(s);
      chk("r0_no_bubble", bus.valid_o, 1'b1);

      // lw $9 then I-type whose rt field is 9 but not consumed
      step(lw9);
      s = idle(); s.rs = 4; s.urs = 1'b1; s.rt = 9; s.urt = 1'b0; s.rd = 9; s.rw = 1'b1;
      step(s);
      chk("itype_no_bubble", bus.valid_o, 1'b1);

      // non-load producer of $9: no stall, one-cycle pass-through
      s = add; s.rs = 5; s.rd = 9;
      step(s);
      s = add; s.rsd = 32'hDEAD_BEEF;
      step(s);
      chk("alu_pass_rsdata", bus.RSdata_o, 64'hDEAD_BEEF);

      // downstream stall for 3 cycles with changing data, then release
      s = add; s.rs = 6; s.rsd = 32'h1234_5678;
      step(s);
      for (int i = 0; i < 3; i++) begin
         s.stall = 1'b1;
         s.rsd   = $urandom;
         step(s);
         chk("stall_hold_rsdata", bus.RSdata_o, 64'h1234_5678);
      end
      s.stall = 1'b0; s.rsd = 32'h0BAD_F00D;
      step(s);
      chk("stall_release_rsdata", bus.RSdata_o, 64'h0BAD_F00D);

      // flush together with hazard and downstream stall
      step(lw9);
      s = add; s.stall = 1'b1; s.flush = 1'b1;
      step(s);
      chk("flush_valid", bus.valid_o, 1'b0);

      // a second load-use bubble, then reset mid-stream
      step(lw9);
      step(add);
      step(add);
      s = add; s.rst = 1'b1;
      step(s);
      chk("rst_rsdata", bus.RSdata_o, 64'd0);

      for (int i = 0; i < 500; i++) begin
         step(rand_stim());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
